// File: rtl/wb_lsu_master_pkg.sv
// Shared types and helpers for the Wishbone load/store initiator.
// Holds the width codes, FSM states, read-data extension and alignment check.
package wb_lsu_master_pkg;

  typedef enum logic [1:0] {
    WB_BYTE = 2'b00,
    WB_HALF = 2'b01,
    WB_WORD = 2'b10
  } wb_width_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } lsu_state_t;

  // Read data arrives right-aligned from the responder; only the extension is done here.
  function automatic logic [31:0] wb_extend(input logic [31:0] data,
                                            input logic [1:0]  width,
                                            input logic        sgn);
    logic [31:0] r;
    case (width)
      2'b00:   r = {{24{sgn & data[7]}},  data[7:0]};
      2'b01:   r = {{16{sgn & data[15]}}, data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic wb_misaligned(input logic [1:0] addr_lo,
                                         input logic [1:0] width);
    logic r;
    case (width)
      2'b00:   r = 1'b0;
      2'b01:   r = addr_lo[0];
      default: r = (addr_lo != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Single-cycle Wishbone link between one initiator and one responder.
// Data is right-aligned; width tells the responder how many bytes are live.
interface WISHBONE_IF #(
  parameter int ADDR_W = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        width;
  logic [31:0]       data_write;
  logic [31:0]       data_read;
  logic              ack;

  modport master (
    output cyc, stb, we, addr, width, data_write,
    input  data_read, ack
  );

  modport slave (
    input  cyc, stb, we, addr, width, data_write,
    output data_read, ack
  );
endinterface

// File: rtl/wb_lsu_master.sv
// Turns single core load/store requests into Wishbone cycles with alignment
// checking, read extension and a no-ack timeout. All outputs come from flops.
//
// state | meaning
// IDLE  | ready for a request; misaligned requests go straight to RESP
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response presented until the core takes it
module wb_lsu_master
  import wb_lsu_master_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_width,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  WISHBONE_IF.master        mem_wb
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t        state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        width_q, width_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              sgn_q, sgn_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      width_q     <= 2'b00;
      wdata_q     <= '0;
      sgn_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      width_q     <= width_d;
      wdata_q     <= wdata_d;
      sgn_q       <= sgn_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    addr_d      = addr_q;
    width_d     = width_q;
    wdata_d     = wdata_q;
    sgn_d       = sgn_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          // Width code 11 is an alias for word; normalise so the bus only sees 00/01/10.
          width_d = (req_width == 2'b11) ? WB_WORD : req_width;
          wdata_d = req_wdata;
          sgn_d   = req_signed;
          if (wb_misaligned(req_addr[1:0], req_width)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = '0;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      BUS: begin
        // Ack is checked first so a late ack on the timeout cycle still completes normally.
        if (mem_wb.ack) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = 1'b0;
          rdata_d     = we_q ? 32'h0 : wb_extend(mem_wb.data_read, width_q, sgn_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
          rdata_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign mem_wb.cyc        = cyc_q;
  assign mem_wb.stb        = cyc_q;
  assign mem_wb.we         = we_q;
  assign mem_wb.addr       = addr_q;
  assign mem_wb.width      = width_q;
  assign mem_wb.data_write = wdata_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Self-checking bench for wb_lsu_master against a byte-array ROM/RAM responder
// with programmable ack delay; expected responses go through a scoreboard queue.
module tb_wb_lsu_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_width;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  WISHBONE_IF #(.ADDR_W(32)) mem_wb ();

  wb_lsu_master #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_width  (req_width),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_wb     (mem_wb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder: byte memory, ROM image at 0x100, ack after ack_wait cycles of cyc.
  logic [7:0]  mem [0:511];
  logic        ack_en;
  logic [7:0]  ack_wait;
  logic [7:0]  wcnt;
  logic [8:0]  ra;
  logic [31:0] rd;

  assign ra = mem_wb.addr[8:0];

  always_comb begin
    rd = '0;
    case (mem_wb.width)
      2'b00:   rd = {24'h0, mem[ra]};
      2'b01:   rd = {16'h0, mem[ra + 9'd1], mem[ra]};
      default: rd = {mem[ra + 9'd3], mem[ra + 9'd2], mem[ra + 9'd1], mem[ra]};
    endcase
  end

  assign mem_wb.data_read = rd;
  assign mem_wb.ack = mem_wb.cyc & mem_wb.stb & ack_en & (wcnt == ack_wait);

  always @(posedge clk) begin
    if (!mem_wb.cyc) wcnt <= 8'd0;
    else             wcnt <= wcnt + 8'd1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem[9'h100] <= 8'h80;
      mem[9'h101] <= 8'h7F;
      mem[9'h102] <= 8'hFF;
      mem[9'h103] <= 8'h12;
    end else if (mem_wb.cyc && mem_wb.stb && mem_wb.we && mem_wb.ack) begin
      mem[ra] <= mem_wb.data_write[7:0];
      if (mem_wb.width != 2'b00) mem[ra + 9'd1] <= mem_wb.data_write[15:8];
      if (mem_wb.width[1]) begin
        mem[ra + 9'd2] <= mem_wb.data_write[23:16];
        mem[ra + 9'd3] <= mem_wb.data_write[31:24];
      end
    end
  end

  int   checks;
  int   failures;
  exp_t sb [$];

  int          lat;
  int          cyc_cnt;
  logic        snap_valid;
  logic        snap_we;
  logic [1:0]  snap_width;
  logic [31:0] snap_data;
  logic [31:0] snap_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    return e;
  endfunction

  // Reference load result built straight from the byte image.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w, input logic s);
    logic [8:0]  b;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [31:0] r;
    b  = a[8:0];
    b0 = mem[b];
    b1 = mem[b + 9'd1];
    if (w == 2'b00)
      r = s && b0[7] ? {24'hFFFFFF, b0} : {24'h0, b0};
    else if (w == 2'b01)
      r = s && b1[7] ? {16'hFFFF, b1, b0} : {16'h0, b1, b0};
    else
      r = {mem[b + 9'd3], mem[b + 9'd2], b1, b0};
    return r;
  endfunction

  task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] w, input logic sgn, input logic [31:0] wdata,
                         input int hold, input exp_t e);
    exp_t got;
    int   n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_width  = w;
    req_signed = sgn;
    req_wdata  = wdata;
    sb.push_back(e);
    @(negedge clk);
    req_valid  = 1'b0;
    lat        = -1;
    cyc_cnt    = 0;
    snap_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        lat = i;
        break;
      end
      if (mem_wb.cyc) cyc_cnt++;
      if (mem_wb.ack) begin
        snap_valid = mem_wb.cyc & mem_wb.stb;
        snap_we    = mem_wb.we;
        snap_width = mem_wb.width;
        snap_data  = mem_wb.data_write;
        snap_addr  = mem_wb.addr;
      end
      @(negedge clk);
    end
    got = sb.pop_front();
    if (lat < 0) begin
      chk({tag, "_rsp_wait"}, 32'h0, 32'h1);
      return;
    end
    chk({tag, "_rdata"}, rsp_rdata, got.rdata);
    chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, got.err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'h0, rsp_valid}, 32'h1);
      chk({tag, "_hold_rdata"}, rsp_rdata, got.rdata);
      chk({tag, "_hold_ready"}, {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_release_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, "_release_idle"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  logic [31:0] e32;

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_width  = 2'b00;
    req_signed = 1'b0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    ack_en     = 1'b1;
    ack_wait   = 8'd0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cyc", {31'h0, mem_wb.cyc}, 32'h0);
    chk("rst_stb", {31'h0, mem_wb.stb}, 32'h0);
    chk("rst_we", {31'h0, mem_wb.we}, 32'h0);
    chk("rst_addr", mem_wb.addr, 32'h0);
    chk("rst_width", {30'h0, mem_wb.width}, 32'h0);
    chk("rst_wdata", mem_wb.data_write, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);

    run_req("ld_word", 1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, mk(32'h12FF7F80, 1'b0));
    chk("ld_word_latency", lat, 32'd1);
    chk("ld_word_cyc_cycles", cyc_cnt, 32'd1);

    run_req("ld_sbyte", 1'b0, 32'h100, 2'b00, 1'b1, 32'h0, 0, mk(32'hFFFFFF80, 1'b0));
    run_req("ld_uhalf", 1'b0, 32'h102, 2'b01, 1'b0, 32'h0, 0, mk(32'h000012FF, 1'b0));
    run_req("ld_shalf", 1'b0, 32'h100, 2'b01, 1'b1, 32'h0, 0, mk(32'h00007F80, 1'b0));
    run_req("ld_ubyte", 1'b0, 32'h102, 2'b00, 1'b0, 32'h0, 0, mk(32'h000000FF, 1'b0));
    run_req("ld_word11", 1'b0, 32'h100, 2'b11, 1'b1, 32'h0, 0, mk(32'h12FF7F80, 1'b0));

    run_req("st_word", 1'b1, 32'h40, 2'b10, 1'b0, 32'hDEADBEEF, 0, mk(32'h0, 1'b0));
    chk("st_word_ack_seen", {31'h0, snap_valid}, 32'h1);
    chk("st_word_we", {31'h0, snap_we}, 32'h1);
    chk("st_word_width", {30'h0, snap_width}, 32'h2);
    chk("st_word_data", snap_data, 32'hDEADBEEF);
    chk("st_word_addr", snap_addr, 32'h40);
    run_req("ld_back", 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 0, mk(32'hDEADBEEF, 1'b0));

    run_req("st_byte", 1'b1, 32'h45, 2'b00, 1'b0, 32'h123456A5, 0, mk(32'h0, 1'b0));
    chk("st_byte_width", {30'h0, snap_width}, 32'h0);
    e32 = model_load(32'h45, 2'b00, 1'b1);
    run_req("ld_sbyte_ram", 1'b0, 32'h45, 2'b00, 1'b1, 32'h0, 0, mk(e32, 1'b0));
    e32 = model_load(32'h44, 2'b10, 1'b0);
    run_req("ld_word_ram", 1'b0, 32'h44, 2'b10, 1'b0, 32'h0, 0, mk(e32, 1'b0));

    run_req("mis_half", 1'b0, 32'h101, 2'b01, 1'b0, 32'h0, 0, mk(32'h0, 1'b1));
    chk("mis_half_no_cyc", cyc_cnt, 32'd0);
    chk("mis_half_latency", lat, 32'd0);
    run_req("mis_word_st", 1'b1, 32'h102, 2'b10, 1'b0, 32'hCAFEF00D, 0, mk(32'h0, 1'b1));
    chk("mis_word_no_cyc", cyc_cnt, 32'd0);
    e32 = model_load(32'h40, 2'b10, 1'b0);
    chk("mis_word_no_write", e32, 32'hDEADBEEF);

    ack_wait = 8'd3;
    run_req("ld_wait3", 1'b0, 32'h100, 2'b00, 1'b0, 32'h0, 0, mk(32'h00000080, 1'b0));
    chk("ld_wait3_cyc_cycles", cyc_cnt, 32'd4);

    ack_wait = 8'd15;
    run_req("ack_at_limit", 1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, mk(32'h12FF7F80, 1'b0));
    chk("ack_at_limit_cyc", cyc_cnt, 32'd16);

    ack_en = 1'b0;
    run_req("timeout", 1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, mk(32'h0, 1'b1));
    chk("timeout_cyc_cycles", cyc_cnt, 32'd16);
    ack_en   = 1'b1;
    ack_wait = 8'd0;

    run_req("bp_load", 1'b0, 32'h102, 2'b01, 1'b1, 32'h0, 5, mk(32'h000012FF, 1'b0));

    ack_en = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h100;
    req_width  = 2'b10;
    req_signed = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_cyc_before", {31'h0, mem_wb.cyc}, 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cyc_async", {31'h0, mem_wb.cyc}, 32'h0);
    chk("mid_rst_stb_async", {31'h0, mem_wb.stb}, 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("post_rst_cyc", {31'h0, mem_wb.cyc}, 32'h0);

    run_req("after_rst_ld", 1'b0, 32'h100, 2'b00, 1'b1, 32'h0, 0, mk(32'hFFFFFF80, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
